// File: rtl/tick_pixel_sequencer.sv
// tick_pixel_sequencer
// Walks an H_PIXELS x V_PIXELS raster one pixel per rate tick and emits a
// test-pattern colour for each coordinate. It supports single-frame or
// continuous operation, start/pause control and frame boundary strobes.
// All outputs are registered, so a pixel appears one cycle after its tick.

module tick_pixel_sequencer #(
   parameter int         H_PIXELS    = 8,
   parameter int         V_PIXELS    = 8,
   parameter logic [7:0] SOLID_COLOR = 8'hFF,
   parameter int         XW          = $clog2(H_PIXELS),
   parameter int         YW          = $clog2(V_PIXELS)
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          tick,
   input  logic          start,
   input  logic          pause_toggle,
   input  logic          continuous,
   input  logic [1:0]    pattern_sel,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic [7:0]    pixel,
   output logic          pixel_valid,
   output logic          frame_start,
   output logic          frame_done,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // The counters wrap at the real raster edge, not at the counter width,
   // so that non-power-of-two sizes work.
   localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);

   state_t        state_q, state_d;
   logic [XW-1:0] cx_q, cx_d;
   logic [YW-1:0] cy_q, cy_d;
   logic [1:0]    pat_q, pat_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [7:0]    pixel_q, pixel_d;
   logic          pixel_valid_q, pixel_valid_d;
   logic          frame_start_q, frame_start_d;
   logic          frame_done_q, frame_done_d;
   logic          busy_q, busy_d;

   logic          at_origin;
   logic          at_last;
   logic [1:0]    pat_now;

   // Gradients put the coordinate in the top bits so that the full colour
   // range is spanned whatever the raster size.
   function automatic logic [7:0] colour_of(input logic [1:0]    pat,
                                            input logic [XW-1:0] cx,
                                            input logic [YW-1:0] cy);
      logic [7:0] grad_x;
      logic [7:0] grad_y;
      logic [7:0] result;
      grad_x = '0;
      grad_y = '0;
      grad_x[7 -: XW] = cx;
      grad_y[7 -: YW] = cy;
      case (pat)
         2'd0:    result = (cx[0] ^ cy[0]) ? 8'hFF : 8'h00;
         2'd1:    result = grad_x;
         2'd2:    result = grad_y;
         default: result = SOLID_COLOR;
      endcase
      return result;
   endfunction

   // Position flags and the pattern in force for the pixel being emitted;
   // the frame's first pixel uses the live selector, which is then latched.
   always_comb begin
      at_origin = (cx_q == '0) && (cy_q == '0);
      at_last   = (cx_q == X_LAST) && (cy_q == Y_LAST);
      pat_now   = at_origin ? pattern_sel : pat_q;
   end

   // Next-state logic: state transitions, raster advance and output strobes.
   always_comb begin
      state_d       = state_q;
      cx_d          = cx_q;
      cy_d          = cy_q;
      pat_d         = pat_q;
      x_d           = x_q;
      y_d           = y_q;
      pixel_d       = pixel_q;
      pixel_valid_d = 1'b0;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            // A tick arriving together with start is dropped on purpose.
            if (start) begin
               state_d = S_RUN;
               cx_d    = '0;
               cy_d    = '0;
            end
         end

         S_RUN: begin
            // Pause has priority over a coincident tick; that tick is lost.
            if (pause_toggle) begin
               state_d = S_PAUSE;
            end else if (tick) begin
               x_d           = cx_q;
               y_d           = cy_q;
               pixel_d       = colour_of(pat_now, cx_q, cy_q);
               pixel_valid_d = 1'b1;
               frame_start_d = at_origin;
               frame_done_d  = at_last;
               if (at_origin) begin
                  pat_d = pattern_sel;
               end
               if (at_last) begin
                  cx_d = '0;
                  cy_d = '0;
                  if (!continuous) begin
                     state_d = S_DONE;
                  end
               end else if (cx_q == X_LAST) begin
                  cx_d = '0;
                  cy_d = cy_q + YW'(1);
               end else begin
                  cx_d = cx_q + XW'(1);
               end
            end
         end

         S_PAUSE: begin
            if (pause_toggle) begin
               state_d = S_RUN;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
   end

   // State, counters and registered outputs; reset clears everything at once.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q       <= S_IDLE;
         cx_q          <= '0;
         cy_q          <= '0;
         pat_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         pixel_q       <= '0;
         pixel_valid_q <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cx_q          <= cx_d;
         cy_q          <= cy_d;
         pat_q         <= pat_d;
         x_q           <= x_d;
         y_q           <= y_d;
         pixel_q       <= pixel_d;
         pixel_valid_q <= pixel_valid_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         busy_q        <= busy_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign pixel       = pixel_q;
   assign pixel_valid = pixel_valid_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_tick_pixel_sequencer.sv
// Directed bench for tick_pixel_sequencer with the default 8x8 raster.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_tick_pixel_sequencer;

   logic       clk;
   logic       nrst;
   logic       tick;
   logic       start;
   logic       pause_toggle;
   logic       continuous;
   logic [1:0] pattern_sel;
   logic [2:0] x;
   logic [2:0] y;
   logic [7:0] pixel;
   logic       pixel_valid;
   logic       frame_start;
   logic       frame_done;
   logic       busy;

   int tests;
   int failures;

   tick_pixel_sequencer dut (
      .clk          (clk),
      .nrst         (nrst),
      .tick         (tick),
      .start        (start),
      .pause_toggle (pause_toggle),
      .continuous   (continuous),
      .pattern_sel  (pattern_sel),
      .x            (x),
      .y            (y),
      .pixel        (pixel),
      .pixel_valid  (pixel_valid),
      .frame_start  (frame_start),
      .frame_done   (frame_done),
      .busy         (busy)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected colour for an 8x8 raster (3-bit coordinates).
   function automatic logic [7:0] expColour(input int pat, input int ex, input int ey);
      logic [7:0] c;
      case (pat)
         0:       c = (((ex ^ ey) & 1) != 0) ? 8'hFF : 8'h00;
         1:       c = 8'(ex << 5);
         2:       c = 8'(ey << 5);
         default: c = 8'hFF;
      endcase
      return c;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of the pulse inputs, then return on the next falling edge.
   task automatic applyStimulus(input logic t, input logic s, input logic p);
      tick         = t;
      start        = s;
      pause_toggle = p;
      @(negedge clk);
      tick         = 1'b0;
      start        = 1'b0;
      pause_toggle = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_x"},     32'(x),           32'd0);
      checkOutput({tag, "_y"},     32'(y),           32'd0);
      checkOutput({tag, "_pixel"}, 32'(pixel),       32'd0);
      checkOutput({tag, "_pv"},    32'(pixel_valid), 32'd0);
      checkOutput({tag, "_fs"},    32'(frame_start), 32'd0);
      checkOutput({tag, "_fd"},    32'(frame_done),  32'd0);
      checkOutput({tag, "_busy"},  32'(busy),        32'd0);
   endtask

   // Emit pixels with running index first..first+count-1, three clocks apart.
   task automatic runPixels(input int first, input int count, input int pat);
      int ex;
      int ey;
      int k;
      for (int i = 0; i < count; i++) begin
         k  = (first + i) % 64;
         ex = k % 8;
         ey = k / 8;
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("p%0d_pv", first + i), 32'(pixel_valid), 32'd1);
         checkOutput($sformatf("p%0d_x", first + i),  32'(x), 32'(ex));
         checkOutput($sformatf("p%0d_y", first + i),  32'(y), 32'(ey));
         checkOutput($sformatf("p%0d_pixel", first + i), 32'(pixel),
                     32'(expColour(pat, ex, ey)));
         checkOutput($sformatf("p%0d_fs", first + i), 32'(frame_start), 32'(k == 0));
         checkOutput($sformatf("p%0d_fd", first + i), 32'(frame_done),  32'(k == 63));
         idleCycles(1);
         checkOutput($sformatf("p%0d_pv_drop", first + i), 32'(pixel_valid), 32'd0);
         idleCycles(1);
      end
   endtask

   initial begin
      tests        = 0;
      failures     = 0;
      nrst         = 1'b0;
      tick         = 1'b0;
      start        = 1'b0;
      pause_toggle = 1'b0;
      continuous   = 1'b0;
      pattern_sel  = 2'd0;

      // Reset values
      #22;
      checkAllZero("reset");
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      // Ticks in IDLE do nothing
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("idle_tick_pv", 32'(pixel_valid), 32'd0);

      // Pattern 0 single frame
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("start_busy", 32'(busy), 32'd1);
      checkOutput("start_pv",   32'(pixel_valid), 32'd0);
      runPixels(0, 64, 0);
      checkOutput("f0_done_busy", 32'(busy), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("f0_extra_pv", 32'(pixel_valid), 32'd0);
      checkOutput("f0_hold_x",   32'(x), 32'd7);
      checkOutput("f0_hold_y",   32'(y), 32'd7);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("done_pause_busy", 32'(busy), 32'd0);

      // Pattern 1, switching the selector mid-frame must not matter
      pattern_sel = 2'd1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      runPixels(0, 20, 1);
      pattern_sel = 2'd3;
      runPixels(20, 44, 1);
      checkOutput("f1_done_busy", 32'(busy), 32'd0);

      // Pattern 2 in continuous mode, then pattern 3 picked up at (0,0)
      pattern_sel = 2'd2;
      continuous  = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      runPixels(0, 64, 2);
      checkOutput("cont_busy", 32'(busy), 32'd1);
      pattern_sel = 2'd3;
      runPixels(64, 1, 3);
      continuous = 1'b0;
      runPixels(65, 63, 3);
      checkOutput("cont_end_busy", 32'(busy), 32'd0);

      // Pause after 10 pixels
      pattern_sel = 2'd0;
      applyStimulus(1'b0, 1'b1, 1'b0);
      runPixels(0, 10, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("pause_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("paused%0d_pv", i), 32'(pixel_valid), 32'd0);
         checkOutput($sformatf("paused%0d_busy", i), 32'(busy), 32'd1);
         idleCycles(2);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      runPixels(10, 54, 0);
      checkOutput("pause_f_done_busy", 32'(busy), 32'd0);

      // Tick and pause together at (3,0)
      applyStimulus(1'b0, 1'b1, 1'b0);
      runPixels(0, 3, 0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("tp_pv",   32'(pixel_valid), 32'd0);
      checkOutput("tp_busy", 32'(busy), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("tp_paused_pv", 32'(pixel_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      runPixels(3, 34, 0);

      // Asynchronous reset just after (4,4) was emitted
      checkOutput("pre_rst_x", 32'(x), 32'd4);
      #2;
      nrst = 1'b0;
      #1;
      checkAllZero("midrst");
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("post_rst_tick_pv", 32'(pixel_valid), 32'd0);
      checkOutput("post_rst_busy",    32'(busy), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("start_tick_pv",   32'(pixel_valid), 32'd0);
      checkOutput("start_tick_busy", 32'(busy), 32'd1);
      runPixels(0, 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/tick_pixel_sequencer.md
Name: tick_pixel_sequencer

Overview:
Consumes the single-cycle rate tick from variable_clock_divider (its adjusted_clk output) and walks a raster of H_PIXELS x V_PIXELS coordinates, advancing one pixel per tick. For each emitted pixel it produces an 8-bit colour from a selectable test pattern. It supports single-frame and continuous operation, start/pause control, and frame boundary strobes. The block sits between the rate divider and the downstream pixel/display writer.

Parameters:
H_PIXELS, 8, pixels per row; 2..256
V_PIXELS, 8, rows per frame; 2..256
SOLID_COLOR, 8'hFF, colour emitted for pattern 3
XW, $clog2(H_PIXELS), x coordinate width (derived; not overridden)
YW, $clog2(V_PIXELS), y coordinate width (derived; not overridden)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
tick  in  1  one-cycle advance strobe from variable_clock_divider
start  in  1  one-cycle pulse; begins a frame from IDLE or DONE
pause_toggle  in  1  one-cycle pulse; RUN<->PAUSE
continuous  in  1  level; 1 = wrap to next frame after the last pixel
pattern_sel  in  2  0 checker, 1 x-gradient, 2 y-gradient, 3 solid
x  out  XW  column of the emitted pixel
y  out  YW  row of the emitted pixel
pixel  out  8  colour of the emitted pixel
pixel_valid  out  1  one-cycle strobe; x/y/pixel valid
frame_start  out  1  one-cycle strobe, coincident with pixel (0,0)
frame_done  out  1  one-cycle strobe, coincident with the last pixel
busy  out  1  high in RUN or PAUSE

Behaviour:
- Reset: nrst asynchronous, active-low; clock clk. State IDLE, internal counters 0, all outputs 0 (x, y, pixel, pixel_valid, frame_start, frame_done, busy).
- All outputs are registered. A tick accepted in cycle N produces pixel_valid in cycle N+1 (latency 1).
- States:
  - IDLE: start -> RUN and clear counters to (0,0). Ticks are ignored.
  - RUN: on tick, emit the current (cx,cy), then advance. cx wraps from H_PIXELS-1 to 0 with cy+1. On the last pixel (H-1,V-1), assert frame_done; then continuous=1 -> counters (0,0), stay RUN; continuous=0 -> DONE. pause_toggle -> PAUSE. start is ignored.
  - PAUSE: ticks are ignored and counters hold. pause_toggle -> RUN. start is ignored.
  - DONE: busy=0, x/y/pixel hold the last values, ticks are ignored. start -> RUN with counters (0,0).
- pause_toggle in IDLE or DONE is ignored.
- busy is registered and follows the state (high in RUN or PAUSE).
- Simultaneous tick and pause_toggle in RUN: pause wins. No pixel is emitted and counters hold; that tick is lost.
- Simultaneous tick and start in IDLE/DONE: enter RUN only; that tick emits nothing.
- pattern_sel is latched when pixel (0,0) is emitted and used for the whole frame. Its value at the (0,0) tick applies to (0,0) itself.
- continuous is sampled on the last-pixel tick.
- Colour for pixel (cx,cy):
  - p0 checker: (cx[0]^cy[0]) ? 8'hFF : 8'h00
  - p1: cx left-justified in 8 bits, low bits zero; XW=3, cx=5 -> 8'hA0
  - p2: cy left-justified in 8 bits, low bits zero
  - p3: SOLID_COLOR
- Non-power-of-2 sizes: counters still wrap at H_PIXELS-1 and V_PIXELS-1, never at 2^XW or 2^YW.
- Reset mid-frame: immediate return to the reset state. No frame_done is emitted.

Test Plan:
- Defaults, pattern 0, continuous=0: start, then 64 ticks spaced 3 clocks apart. Expect:
  - 1st pixel_valid: (0,0), pixel 00, frame_start=1.
  - 2nd: (1,0), pixel FF.
  - 64th: (7,7), pixel 00, frame_done=1.
  - Afterwards busy=0; a 65th tick gives no pixel_valid.
- Pattern 1: pixel (5,2) = A0, (7,*) = E0. Pattern 2: pixel (*,3) = 60. Changing pattern_sel to 3 mid-frame has no effect until the next frame's (0,0).
- Pause: pause_toggle after 10 pixels, then 5 ticks -> no pixel_valid and busy=1. pause_toggle again, then one tick -> (2,1).
- Continuous=1: the tick after (7,7) gives (0,0) with frame_start=1, busy stays 1. Dropping continuous before the next (7,7) -> DONE after that frame.
- Tick and pause_toggle in the same cycle at position (3,0) -> no pixel, PAUSE. After resume, the next tick gives (3,0).
- Assert nrst at pixel (4,4) -> all outputs 0, IDLE. Ticks give nothing until start; then the first pixel is (0,0) with frame_start.
